// File: rtl/can_tx_scheduler.sv
// CAN transmit mailbox scheduler: holds NUM_MB frames, arbitrates by CAN bus priority,
// and hands the winner to the transmit control unit, then retires, retries or drops it.
module can_tx_scheduler #(
  parameter int NUM_MB    = 3,
  parameter int MAX_RETRY = 0
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [NUM_MB-1:0] mb_wr,
  input  logic [28:0]       mb_ID,
  input  logic [3:0]        mb_pkt_size,
  input  logic              mb_RTR,
  input  logic              mb_EXT,
  input  logic [63:0]       mb_data,
  input  logic [NUM_MB-1:0] mb_abort,
  input  logic              tx_busy,
  input  logic              tx_done,
  input  logic              tx_arb_loss,
  output logic              tx_pkt_ready,
  output logic [28:0]       tx_ID,
  output logic [3:0]        tx_pkt_size,
  output logic              tx_RTR,
  output logic              tx_EXT,
  output logic [63:0]       tx_data,
  output logic [NUM_MB-1:0] mb_pending,
  output logic [NUM_MB-1:0] mb_done,
  output logic [NUM_MB-1:0] mb_fail,
  output logic [2:0]        active_mb,
  output logic              busy
);

  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_REQUEST, S_TX} state_t;

  state_t state, state_next;

  logic [28:0]   id_q    [NUM_MB];
  logic [3:0]    dlc_q   [NUM_MB];
  logic          rtr_q   [NUM_MB];
  logic          ext_q   [NUM_MB];
  logic [63:0]   data_q  [NUM_MB];
  logic [RW-1:0] retry_q [NUM_MB];
  logic [31:0]   prio_key[NUM_MB];

  logic          abort_lat;
  logic          win_found;
  logic [2:0]    win_idx;
  logic [31:0]   win_key;
  logic [2:0]    flight_idx;
  logic          abort_hit;
  logic          abort_eff;
  logic [RW-1:0] cur_retry;
  logic [RW-1:0] new_retry;
  logic          ev_done;
  logic          ev_err;
  logic          ev_drop;
  logic [3:0]    load_dlc;

  assign load_dlc     = (mb_pkt_size > 4'd8) ? 4'd8 : mb_pkt_size;
  assign busy         = (state != S_IDLE);
  assign tx_pkt_ready = (state == S_REQUEST);

  // Bus-order key: the numerically lowest key wins arbitration on the wire.
  always_comb begin
    for (int i = 0; i < NUM_MB; i++) begin
      prio_key[i] = ext_q[i] ? {id_q[i][28:18], 1'b1, 1'b1, id_q[i][17:0], rtr_q[i]}
                             : {id_q[i][10:0], rtr_q[i], 1'b0, 18'd0, 1'b0};
    end
  end

  // Strict less-than keeps the lower index on equal keys.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_key   = '1;
    for (int i = 0; i < NUM_MB; i++) begin
      if (mb_pending[i] && (!win_found || prio_key[i] < win_key)) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
        win_key   = prio_key[i];
      end
    end
  end

  // During SELECT the winner is already treated as in flight so an abort to it is latched.
  always_comb begin
    flight_idx = (state == S_SELECT) ? win_idx : active_mb;
    abort_hit  = 1'b0;
    cur_retry  = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (flight_idx == 3'(i)) abort_hit = mb_abort[i];
      if (active_mb == 3'(i))  cur_retry = retry_q[i];
    end
    new_retry = cur_retry + RW'(1);
    abort_eff = abort_lat | abort_hit;
    ev_done   = (state == S_TX) && tx_done;
    ev_err    = (state == S_TX) && !tx_done && (tx_arb_loss || !tx_busy);
    ev_drop   = ev_err && (abort_eff || ((MAX_RETRY != 0) && (new_retry == RETRY_LIM)));
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if ((|mb_pending) && !tx_busy) state_next = S_SELECT;
      S_SELECT:  state_next = win_found ? S_REQUEST : S_IDLE;
      S_REQUEST: if (tx_busy) state_next = S_TX;
      S_TX:      if (ev_done || ev_err) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_MB; i++) begin
        id_q[i]    <= '0;
        dlc_q[i]   <= '0;
        rtr_q[i]   <= 1'b0;
        ext_q[i]   <= 1'b0;
        data_q[i]  <= '0;
        retry_q[i] <= '0;
      end
      mb_pending  <= '0;
      mb_done     <= '0;
      mb_fail     <= '0;
      tx_ID       <= '0;
      tx_pkt_size <= '0;
      tx_RTR      <= 1'b0;
      tx_EXT      <= 1'b0;
      tx_data     <= '0;
      active_mb   <= '0;
      abort_lat   <= 1'b0;
    end else begin
      mb_done <= '0;
      mb_fail <= '0;
      for (int i = 0; i < NUM_MB; i++) begin
        if (mb_wr[i] && !mb_pending[i]) begin
          id_q[i]       <= mb_ID;
          dlc_q[i]      <= load_dlc;
          rtr_q[i]      <= mb_RTR;
          ext_q[i]      <= mb_EXT;
          data_q[i]     <= mb_data;
          retry_q[i]    <= '0;
          mb_pending[i] <= 1'b1;
        end else if (busy && flight_idx == 3'(i)) begin
          if (ev_done) begin
            mb_pending[i] <= 1'b0;
            mb_done[i]    <= 1'b1;
            retry_q[i]    <= '0;
          end else if (ev_drop) begin
            mb_pending[i] <= 1'b0;
            mb_fail[i]    <= 1'b1;
            retry_q[i]    <= '0;
          end else if (ev_err) begin
            retry_q[i]    <= new_retry;
          end
        end else if (mb_abort[i] && mb_pending[i]) begin
          mb_pending[i] <= 1'b0;
          mb_fail[i]    <= 1'b1;
          retry_q[i]    <= '0;
        end
      end

      if (state == S_SELECT && win_found) begin
        active_mb <= win_idx;
        for (int i = 0; i < NUM_MB; i++) begin
          if (win_idx == 3'(i)) begin
            tx_ID       <= id_q[i];
            tx_pkt_size <= dlc_q[i];
            tx_RTR      <= rtr_q[i];
            tx_EXT      <= ext_q[i];
            tx_data     <= data_q[i];
          end
        end
      end

      if (state_next == S_IDLE)  abort_lat <= 1'b0;
      else if (busy && abort_hit) abort_lat <= 1'b1;
    end
  end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed bench for can_tx_scheduler (3 mailboxes, two failed attempts allowed).
module tb_can_tx_scheduler;

  logic        clk;
  logic        nRST;
  logic [2:0]  mb_wr;
  logic [28:0] mb_ID;
  logic [3:0]  mb_pkt_size;
  logic        mb_RTR;
  logic        mb_EXT;
  logic [63:0] mb_data;
  logic [2:0]  mb_abort;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_arb_loss;
  logic        tx_pkt_ready;
  logic [28:0] tx_ID;
  logic [3:0]  tx_pkt_size;
  logic        tx_RTR;
  logic        tx_EXT;
  logic [63:0] tx_data;
  logic [2:0]  mb_pending;
  logic [2:0]  mb_done;
  logic [2:0]  mb_fail;
  logic [2:0]  active_mb;
  logic        busy;

  int checks = 0;
  int errors = 0;

  can_tx_scheduler #(.NUM_MB(3), .MAX_RETRY(2)) dut (
    .clk(clk), .nRST(nRST),
    .mb_wr(mb_wr), .mb_ID(mb_ID), .mb_pkt_size(mb_pkt_size), .mb_RTR(mb_RTR),
    .mb_EXT(mb_EXT), .mb_data(mb_data), .mb_abort(mb_abort),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_arb_loss(tx_arb_loss),
    .tx_pkt_ready(tx_pkt_ready), .tx_ID(tx_ID), .tx_pkt_size(tx_pkt_size),
    .tx_RTR(tx_RTR), .tx_EXT(tx_EXT), .tx_data(tx_data),
    .mb_pending(mb_pending), .mb_done(mb_done), .mb_fail(mb_fail),
    .active_mb(active_mb), .busy(busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [2:0] wr, input logic [28:0] id, input logic [3:0] dlc,
                      input logic rtr, input logic ext, input logic [63:0] data);
    mb_wr       = wr;
    mb_ID       = id;
    mb_pkt_size = dlc;
    mb_RTR      = rtr;
    mb_EXT      = ext;
    mb_data     = data;
    step();
    mb_wr = '0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (tx_pkt_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_req"}, 64'(tx_pkt_ready), 64'd1);
  endtask

  task automatic serve_done(input string tag, input int idx, input logic [28:0] id);
    wait_req(tag);
    chk({tag, "_act"}, 64'(active_mb), 64'(idx));
    chk({tag, "_id"}, 64'(tx_ID), 64'(id));
    tx_busy = 1'b1;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    tx_busy = 1'b0;
    chk({tag, "_done"}, 64'(mb_done), 64'd1 << idx);
  endtask

  initial begin
    nRST = 1'b0; mb_wr = '0; mb_ID = '0; mb_pkt_size = '0; mb_RTR = 1'b0; mb_EXT = 1'b0;
    mb_data = '0; mb_abort = '0; tx_busy = 1'b0; tx_done = 1'b0; tx_arb_loss = 1'b0;
    step(); step();
    chk("rst_pending", 64'(mb_pending), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(tx_pkt_ready), 64'd0);
    chk("rst_txid", 64'(tx_ID), 64'd0);
    chk("rst_active", 64'(active_mb), 64'd0);
    nRST = 1'b1;
    step();

    // Single standard frame, cycle by cycle
    load(3'b001, 29'h123, 4'd2, 1'b0, 1'b0, 64'hBEEF);
    chk("t1_pending", 64'(mb_pending), 64'b001);
    chk("t1_idle", 64'(busy), 64'd0);
    step();
    chk("t1_select_busy", 64'(busy), 64'd1);
    chk("t1_select_ready", 64'(tx_pkt_ready), 64'd0);
    step();
    chk("t1_ready", 64'(tx_pkt_ready), 64'd1);
    chk("t1_id", 64'(tx_ID), 64'h123);
    chk("t1_size", 64'(tx_pkt_size), 64'd2);
    chk("t1_data", tx_data, 64'hBEEF);
    chk("t1_active", 64'(active_mb), 64'd0);
    tx_busy = 1'b1;
    step();
    chk("t1_tx_ready", 64'(tx_pkt_ready), 64'd0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    tx_busy = 1'b0;
    chk("t1_done", 64'(mb_done), 64'b001);
    chk("t1_cleared", 64'(mb_pending), 64'b000);
    step();
    chk("t1_done_pulse", 64'(mb_done), 64'b000);

    // Three-way arbitration, extended frame with equal base loses to standard
    tx_busy = 1'b1;
    load(3'b001, 29'h200, 4'd1, 1'b0, 1'b0, 64'h11);
    load(3'b010, 29'h0800_0000, 4'd8, 1'b0, 1'b1, 64'h22);
    load(3'b100, 29'h100, 4'd3, 1'b0, 1'b0, 64'h33);
    chk("t2_pending", 64'(mb_pending), 64'b111);
    tx_busy = 1'b0;
    serve_done("t2_first", 2, 29'h100);
    serve_done("t2_second", 0, 29'h200);
    serve_done("t2_third", 1, 29'h0800_0000);
    chk("t2_ext", 64'(tx_EXT), 64'd1);
    chk("t2_empty", 64'(mb_pending), 64'b000);

    // RTR bit breaks the tie against the index order
    tx_busy = 1'b1;
    load(3'b010, 29'h050, 4'd0, 1'b1, 1'b0, 64'h0);
    load(3'b001, 29'h050, 4'd0, 1'b0, 1'b0, 64'h0);
    tx_busy = 1'b0;
    serve_done("t3_data", 0, 29'h050);
    chk("t3_data_rtr", 64'(tx_RTR), 64'd0);
    serve_done("t3_remote", 1, 29'h050);
    chk("t3_remote_rtr", 64'(tx_RTR), 64'd1);

    // Remote frame on the lower index loses to data frame on a higher index
    tx_busy = 1'b1;
    load(3'b001, 29'h050, 4'd0, 1'b1, 1'b0, 64'h0);
    load(3'b100, 29'h050, 4'd0, 1'b0, 1'b0, 64'h0);
    tx_busy = 1'b0;
    serve_done("t3b_data", 2, 29'h050);
    serve_done("t3b_remote", 0, 29'h050);

    // Identical keys through one multi-bit write: lower index first
    tx_busy = 1'b1;
    load(3'b011, 29'h050, 4'd1, 1'b0, 1'b0, 64'h5);
    chk("tie_pending", 64'(mb_pending), 64'b011);
    tx_busy = 1'b0;
    serve_done("tie_a", 0, 29'h050);
    serve_done("tie_b", 1, 29'h050);

    // Retry limit: two arbitration losses drop mailbox 1
    load(3'b010, 29'h321, 4'd1, 1'b0, 1'b0, 64'h7);
    wait_req("t4_try1");
    chk("t4_try1_act", 64'(active_mb), 64'd1);
    tx_busy = 1'b1;
    step();
    tx_arb_loss = 1'b1;
    step();
    tx_arb_loss = 1'b0;
    tx_busy = 1'b0;
    chk("t4_loss1_pending", 64'(mb_pending), 64'b010);
    chk("t4_loss1_fail", 64'(mb_fail), 64'b000);
    wait_req("t4_try2");
    chk("t4_try2_act", 64'(active_mb), 64'd1);
    tx_busy = 1'b1;
    step();
    tx_arb_loss = 1'b1;
    step();
    tx_arb_loss = 1'b0;
    tx_busy = 1'b0;
    chk("t4_loss2_fail", 64'(mb_fail), 64'b010);
    chk("t4_loss2_pending", 64'(mb_pending), 64'b000);
    chk("t4_loss2_busy", 64'(busy), 64'd0);

    // Bus error (tx_busy drops without result) is retried, then completes
    load(3'b001, 29'h055, 4'd1, 1'b0, 1'b0, 64'h9);
    wait_req("err_try1");
    tx_busy = 1'b1;
    step();
    tx_busy = 1'b0;
    step();
    chk("err_pending", 64'(mb_pending), 64'b001);
    chk("err_no_done", 64'(mb_done), 64'b000);
    chk("err_no_fail", 64'(mb_fail), 64'b000);
    chk("err_idle", 64'(busy), 64'd0);
    serve_done("err_retry", 0, 29'h055);

    // Abort of an in-flight mailbox followed by a loss: dropped, no re-request
    load(3'b001, 29'h300, 4'd1, 1'b0, 1'b0, 64'hA);
    wait_req("t5_flight");
    tx_busy = 1'b1;
    step();
    mb_abort = 3'b001;
    step();
    mb_abort = 3'b000;
    chk("t5_latched_pending", 64'(mb_pending), 64'b001);
    chk("t5_latched_fail", 64'(mb_fail), 64'b000);
    tx_arb_loss = 1'b1;
    step();
    tx_arb_loss = 1'b0;
    tx_busy = 1'b0;
    chk("t5_fail", 64'(mb_fail), 64'b001);
    chk("t5_pending", 64'(mb_pending), 64'b000);
    step(); step();
    chk("t5_no_rereq", 64'(tx_pkt_ready), 64'd0);
    chk("t5_no_busy", 64'(busy), 64'd0);

    // Abort of a pending, idle mailbox
    tx_busy = 1'b1;
    load(3'b100, 29'h0AA, 4'd1, 1'b0, 1'b0, 64'hB);
    chk("t5b_pending", 64'(mb_pending), 64'b100);
    mb_abort = 3'b100;
    step();
    mb_abort = 3'b000;
    chk("t5b_cleared", 64'(mb_pending), 64'b000);
    chk("t5b_fail", 64'(mb_fail), 64'b100);
    step();
    chk("t5b_fail_pulse", 64'(mb_fail), 64'b000);
    tx_busy = 1'b0;

    // Rewrite of a pending mailbox is ignored; oversize DLC clamps to 8
    tx_busy = 1'b1;
    load(3'b001, 29'h010, 4'd15, 1'b0, 1'b0, 64'hC);
    load(3'b001, 29'h020, 4'd1, 1'b0, 1'b0, 64'hD);
    tx_busy = 1'b0;
    serve_done("t6", 0, 29'h010);
    chk("t6_dlc_clamp", 64'(tx_pkt_size), 64'd8);
    chk("t6_data", tx_data, 64'hC);

    // Reset during a frame
    load(3'b100, 29'h0AB, 4'd4, 1'b0, 1'b0, 64'hE);
    wait_req("t7");
    tx_busy = 1'b1;
    step();
    nRST = 1'b0;
    #1;
    chk("t7_ready", 64'(tx_pkt_ready), 64'd0);
    chk("t7_txid", 64'(tx_ID), 64'd0);
    chk("t7_pending", 64'(mb_pending), 64'd0);
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_active", 64'(active_mb), 64'd0);
    step();
    chk("t7_no_done", 64'(mb_done), 64'd0);
    chk("t7_no_fail", 64'(mb_fail), 64'd0);
    tx_busy = 1'b0;
    nRST = 1'b1;
    step();
    chk("t7_post_busy", 64'(busy), 64'd0);
    chk("t7_post_pending", 64'(mb_pending), 64'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
- Transmit mailbox controller between the wishbone register slave and the CAN transmit control unit.
- Holds NUM_MB independently loadable TX mailboxes and picks the pending mailbox with the highest CAN bus priority.
- Drives the single TCU packet interface (tx_pkt_ready / tx_ID / ...), then retires, retries or aborts each mailbox from the TCU's tx_done / tx_arb_loss results.

Parameters:
- NUM_MB, 3, number of TX mailboxes (1..8).
- MAX_RETRY, 0, failed attempts (arbitration loss or error) before a mailbox is dropped; 0 = unlimited.

Ports:
- clk  in  1  CAN-domain clock; the only clock.
- nRST  in  1  asynchronous active-low reset.
- mb_wr  in  NUM_MB  one-hot load strobe; the mailbox loads the shared mb_* fields.
- mb_ID  in  29  identifier; standard frames use mb_ID[10:0].
- mb_pkt_size  in  4  DLC, 0..8; values 9..15 are clamped to 8.
- mb_RTR  in  1  remote frame.
- mb_EXT  in  1  extended (29-bit) identifier.
- mb_data  in  64  payload.
- mb_abort  in  NUM_MB  abort request per mailbox, one-cycle pulse.
- tx_busy  in  1  TCU frame in progress.
- tx_done  in  1  TCU frame completed successfully, one-cycle pulse.
- tx_arb_loss  in  1  TCU lost arbitration, one-cycle pulse.
- tx_pkt_ready  out  1  request to TCU.
- tx_ID  out  29  selected mailbox ID.
- tx_pkt_size  out  4  selected DLC.
- tx_RTR  out  1  selected RTR.
- tx_EXT  out  1  selected EXT.
- tx_data  out  64  selected payload.
- mb_pending  out  NUM_MB  mailbox holds an untransmitted frame.
- mb_done  out  NUM_MB  pulse: frame transmitted.
- mb_fail  out  NUM_MB  pulse: dropped after MAX_RETRY failed attempts, or aborted.
- active_mb  out  3  index of the in-flight mailbox; valid while busy.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: FSM to IDLE; all mailbox contents, retry counters and outputs to 0.
- Load: mb_wr[i] loads mailbox i and sets pending[i] next cycle, but only when i is not pending and not in flight; otherwise the write is ignored.
- Multiple bits set in mb_wr: all of the selected idle mailboxes load the same fields.
- Priority key per mailbox, 32 bits, lower value wins:
  - base = EXT ? ID[28:18] : ID[10:0].
  - key = {base, EXT ? 1 : RTR, EXT, EXT ? ID[17:0] : 18'b0, EXT ? RTR : 0}.
  - Equal keys: the lower mailbox index wins.
- FSM:
  - IDLE: when any pending bit is set and tx_busy = 0 -> SELECT.
  - SELECT, 1 cycle: latch the winner's fields into the tx_* registers and set active_mb -> REQUEST.
  - REQUEST: tx_pkt_ready = 1. On tx_busy = 1, drop tx_pkt_ready -> TX.
  - TX, ends on whichever of the following occurs:
    - tx_done: clear pending[active], pulse mb_done[active] for 1 cycle, reset the retry counter -> IDLE.
    - tx_arb_loss: increment the retry counter -> IDLE; the mailbox stays pending and re-enters arbitration, so a higher-priority mailbox loaded meanwhile wins.
    - tx_busy falls with no tx_done and no tx_arb_loss in the same cycle: treated as an error; same handling as tx_arb_loss.
- Retry limit: when MAX_RETRY != 0 and the incremented counter equals MAX_RETRY, clear pending and pulse mb_fail instead of retrying.
- tx_done and tx_arb_loss in the same cycle: tx_done wins.
- tx_* outputs hold their last values outside REQUEST/TX.
- Abort:
  - Mailbox pending and not in flight: pending clears next cycle and mb_fail pulses.
  - Mailbox in flight: the abort is latched. On tx_done the mailbox retires normally with mb_done. On loss or error it retires with mb_fail and no retry.
  - Abort of a non-pending mailbox is ignored.
- Reset mid-frame: all state is lost and no mb_done or mb_fail pulses are issued.

Test Plan:
- Load MB0, std ID 0x123, DLC 2, data 0xBEEF. SELECT then tx_pkt_ready; tx_ID = 0x123. Raise tx_busy, then pulse tx_done -> mb_done[0] pulses 1 cycle, mb_pending = 000.
- MB0 std 0x200, MB1 ext 0x0800_0000 (base 0x200), MB2 std 0x100, all loaded together:
  - Transmission order is MB2, MB0, MB1.
  - Requests made on one cycle of tx_done each.
- MB0 and MB1 with std ID 0x050, RTR = 0 and RTR = 1 respectively -> MB0 first. Identical keys -> lower index first.
- MAX_RETRY = 2, MB1 in flight, two tx_arb_loss pulses:
  - First loss: re-request.
  - Second loss: mb_fail[1] pulses, pending[1] = 0, busy = 0.
- Abort:
  - MB0 in flight: mb_abort[0], then tx_arb_loss -> mb_fail[0] pulses, no re-request.
  - MB2 pending and idle: mb_abort[2] -> pending[2] clears next cycle.
- Write mb_wr[0] while MB0 is pending with ID 0x10, new ID 0x20 -> tx_ID still 0x10 at the request.
- Deassert nRST during TX -> all outputs 0 immediately, no status pulses.
